// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack port and the instruction output handshake of
// the fetch stage, bundled so the fetch unit and its neighbours share one port.
`timescale 1ns/1ps
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        input  imem_ack, imem_data, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        output imem_ack, imem_data, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one-outstanding-request imem port feeding a small
// prefetch FIFO of {instruction, pc}, with redirect flush and stale-ack drop.
//
//   state | meaning
//   IDLE  | no request outstanding; issue when FIFO has room
//   WAIT  | request outstanding, its response will be kept
//   DROP  | request outstanding, its response is stale and will be discarded
`timescale 1ns/1ps
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    fetch_unit_if.master     bus,
    output logic [PTR_W:0]   fifo_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    state_t             state, state_nxt;
    logic [31:0]        fetch_pc, fetch_pc_nxt;
    logic [31:0]        req_addr, req_addr_nxt;
    logic [31:0]        mem_inst [DEPTH];
    logic [31:0]        mem_pc   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count, count_after;
    logic [31:0]        target;
    logic               push, pop;

    assign target      = redirect_pc & ~32'd3;
    assign push        = (state == WAIT) && bus.imem_ack && !redirect;
    assign pop         = (count != '0) && bus.inst_ready && !redirect;
    assign count_after = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_addr_nxt = req_addr;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_nxt = target;
                end else if (count < FULL) begin
                    req_addr_nxt = fetch_pc;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    state_nxt    = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_nxt = target;
                    state_nxt    = bus.imem_ack ? IDLE : DROP;
                end else if (bus.imem_ack) begin
                    // chain the next request in the ack cycle for 1 word/cycle
                    if (count_after < FULL) begin
                        req_addr_nxt = fetch_pc;
                        fetch_pc_nxt = fetch_pc + 32'd4;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    fetch_pc_nxt = target;
                end
                if (bus.imem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_addr <= req_addr_nxt;
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem_inst[wr_ptr] <= bus.imem_data;
                    mem_pc[wr_ptr]   <= req_addr;
                    wr_ptr           <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count_after;
            end
        end
    end

    assign bus.imem_req   = (state != IDLE);
    assign bus.imem_addr  = req_addr;
    assign bus.inst_valid = (count != '0);
    assign bus.inst_out   = mem_inst[rd_ptr];
    assign bus.inst_pc    = mem_pc[rd_ptr];
    assign fifo_count     = count;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle vectors, a wrap-around sequence on a second
// instance, and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_fetch_unit;
    logic        clock = 1'b0;
    logic        reset, redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  fifo_count;
    logic        reset_w, redirect_w;
    logic [31:0] redirect_pc_w;
    logic [2:0]  fifo_count_w;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    fetch_unit_if bus ();
    fetch_unit_if bus_w ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4), .PTR_W(2)) dut (
        .clock(clock), .reset(reset), .redirect(redirect),
        .redirect_pc(redirect_pc), .bus(bus), .fifo_count(fifo_count)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4), .PTR_W(2)) u_wrap (
        .clock(clock), .reset(reset_w), .redirect(redirect_w),
        .redirect_pc(redirect_pc_w), .bus(bus_w), .fifo_count(fifo_count_w)
    );

    typedef struct {
        logic        rst, redir;
        logic [31:0] rpc;
        logic        ack, rdy;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic vec_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                                input logic ack, input logic rdy, input logic req,
                                input logic [31:0] addr, input logic valid,
                                input logic [31:0] pc, input logic [2:0] cnt);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.ack = ack; v.rdy = rdy;
        v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base, exp_pc, want_addr, prev_addr, rpc;
        int          nreq, npop, cnt_m, wait_cnt, npops;
        logic        stale, prev_req, prev_ack, pop_m, accept;

        reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
        bus.imem_ack = 1'b0; bus.imem_data = '0; bus.inst_ready = 1'b0;
        reset_w = 1'b1; redirect_w = 1'b0; redirect_pc_w = '0;
        bus_w.imem_ack = 1'b0; bus_w.imem_data = '0; bus_w.inst_ready = 1'b0;

        // rst redir rpc ack rdy | req addr valid pc cnt
        vt.push_back(mk(1, 0, 32'h0,   1, 1, 0, 32'h0,   0, 32'h0,   0));
        vt.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'h0,   0, 32'h0,   0));
        vt.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'h4,   1, 32'h0,   1));
        vt.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'h8,   1, 32'h4,   1));
        vt.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'hC,   1, 32'h8,   1));
        vt.push_back(mk(1, 0, 32'h0,   1, 0, 0, 32'h0,   0, 32'h0,   0));
        vt.push_back(mk(0, 0, 32'h0,   1, 0, 1, 32'h0,   0, 32'h0,   0));
        vt.push_back(mk(0, 0, 32'h0,   1, 0, 1, 32'h4,   1, 32'h0,   1));
        vt.push_back(mk(0, 0, 32'h0,   1, 0, 1, 32'h8,   1, 32'h0,   2));
        vt.push_back(mk(0, 0, 32'h0,   1, 0, 1, 32'hC,   1, 32'h0,   3));
        vt.push_back(mk(0, 0, 32'h0,   1, 0, 0, 32'hC,   1, 32'h0,   4));
        vt.push_back(mk(0, 0, 32'h0,   1, 0, 0, 32'hC,   1, 32'h0,   4));
        vt.push_back(mk(0, 0, 32'h0,   0, 1, 0, 32'hC,   1, 32'h4,   3));
        vt.push_back(mk(0, 0, 32'h0,   0, 1, 1, 32'h10,  1, 32'h8,   2));
        vt.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'h14,  1, 32'hC,   2));
        vt.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'h18,  1, 32'h10,  2));
        vt.push_back(mk(0, 1, 32'h203, 1, 1, 0, 32'h18,  0, 32'h0,   0));
        vt.push_back(mk(0, 0, 32'h0,   0, 1, 1, 32'h200, 0, 32'h0,   0));
        vt.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'h204, 1, 32'h200, 1));
        vt.push_back(mk(0, 1, 32'h100, 0, 0, 1, 32'h204, 0, 32'h0,   0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 1, 32'h204, 0, 32'h0,   0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 1, 32'h204, 0, 32'h0,   0));
        vt.push_back(mk(0, 0, 32'h0,   1, 0, 0, 32'h204, 0, 32'h0,   0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 1, 32'h100, 0, 32'h0,   0));
        vt.push_back(mk(0, 0, 32'h0,   1, 0, 1, 32'h104, 1, 32'h100, 1));
        vt.push_back(mk(1, 0, 32'h0,   1, 0, 0, 32'h0,   0, 32'h0,   0));
        vt.push_back(mk(0, 0, 32'h0,   1, 0, 1, 32'h0,   0, 32'h0,   0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 1, 32'h0,   0, 32'h0,   0));

        @(negedge clock);
        foreach (vt[i]) begin
            reset          = vt[i].rst;
            redirect       = vt[i].redir;
            redirect_pc    = vt[i].rpc;
            bus.imem_ack   = vt[i].ack;
            bus.imem_data  = mem_word(bus.imem_addr);
            bus.inst_ready = vt[i].rdy;
            @(negedge clock);
            chk($sformatf("vec%0d req", i), 32'(bus.imem_req), 32'(vt[i].req));
            chk($sformatf("vec%0d addr", i), bus.imem_addr, vt[i].addr);
            chk($sformatf("vec%0d valid", i), 32'(bus.inst_valid), 32'(vt[i].valid));
            chk($sformatf("vec%0d count", i), 32'(fifo_count), 32'(vt[i].cnt));
            if (vt[i].valid) begin
                chk($sformatf("vec%0d pc", i), bus.inst_pc, vt[i].pc);
                chk($sformatf("vec%0d out", i), bus.inst_out, mem_word(vt[i].pc));
            end
            if (vt[i].rst) begin
                chk($sformatf("vec%0d reset_pc", i), bus.inst_pc, 32'h0);
                chk($sformatf("vec%0d reset_out", i), bus.inst_out, 32'h0);
            end
        end

        // Address wrap and FIFO pointer wrap on the instance starting near 2^32
        base = 32'hFFFF_FFF8;
        nreq = 0;
        npop = 0;
        reset_w = 1'b1;
        @(negedge clock);
        chk("wrap reset req", 32'(bus_w.imem_req), 32'h0);
        chk("wrap reset addr", bus_w.imem_addr, base);
        reset_w = 1'b0;
        for (int cyc = 0; cyc < 300 && npop < 10; cyc++) begin
            if (bus_w.imem_req) begin
                chk($sformatf("wrap addr%0d", nreq), bus_w.imem_addr, base + 32'(4 * nreq));
                nreq++;
            end
            chk("wrap count range", 32'(fifo_count_w <= 3'd4), 32'h1);
            bus_w.imem_ack    = bus_w.imem_req;
            bus_w.imem_data   = mem_word(bus_w.imem_addr);
            bus_w.inst_ready  = 1'($urandom_range(0, 1));
            if (bus_w.inst_valid && bus_w.inst_ready) begin
                chk($sformatf("wrap pc%0d", npop), bus_w.inst_pc, base + 32'(4 * npop));
                chk($sformatf("wrap out%0d", npop), bus_w.inst_out, mem_word(base + 32'(4 * npop)));
                npop++;
            end
            @(negedge clock);
        end
        chk("wrap pops done", 32'(npop), 32'd10);
        bus_w.imem_ack = 1'b0;

        // Randomized run: memory with 0..3 cycle latency, random ready and redirects
        reset = 1'b1; redirect = 1'b0; bus.imem_ack = 1'b0; bus.inst_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        exp_pc = 32'h0; want_addr = 32'h0; prev_addr = 32'h0;
        cnt_m = 0; stale = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; npops = 0;
        wait_cnt = $urandom_range(0, 3);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd count", 32'(fifo_count), 32'(cnt_m));
            chk("rnd valid", 32'(bus.inst_valid), 32'(cnt_m != 0));
            if (prev_req && !prev_ack) begin
                chk("rnd req_hold", 32'(bus.imem_req), 32'h1);
            end
            if (bus.imem_req) begin
                if (!prev_req || prev_ack) begin
                    chk("rnd new_addr", bus.imem_addr, want_addr);
                    want_addr = want_addr + 32'd4;
                end else begin
                    chk("rnd addr_hold", bus.imem_addr, prev_addr);
                end
            end

            redirect = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            redirect_pc = rpc;
            bus.inst_ready = ($urandom_range(0, 3) != 0);
            if (bus.imem_req) begin
                if (wait_cnt == 0) begin
                    bus.imem_ack  = 1'b1;
                    bus.imem_data = mem_word(bus.imem_addr);
                    wait_cnt      = $urandom_range(0, 3);
                end else begin
                    bus.imem_ack  = 1'b0;
                    bus.imem_data = $urandom;
                    wait_cnt--;
                end
            end else begin
                bus.imem_ack  = ($urandom_range(0, 3) == 0);
                bus.imem_data = $urandom;
            end

            pop_m = (cnt_m != 0) && bus.inst_ready && !redirect;
            if (pop_m) begin
                chk("rnd pop_pc", bus.inst_pc, exp_pc);
                chk("rnd pop_out", bus.inst_out, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                npops++;
            end
            accept = bus.imem_ack && bus.imem_req && !redirect && !stale;
            if (redirect) begin
                cnt_m     = 0;
                exp_pc    = rpc & ~32'd3;
                want_addr = rpc & ~32'd3;
                stale     = bus.imem_req && !bus.imem_ack;
            end else begin
                cnt_m = cnt_m + int'(accept) - int'(pop_m);
                if (bus.imem_ack && bus.imem_req) stale = 1'b0;
            end
            prev_req  = bus.imem_req;
            prev_ack  = bus.imem_ack && bus.imem_req;
            prev_addr = bus.imem_addr;
            @(negedge clock);
        end
        chk("rnd progress", 32'(npops >= 300), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits upstream of the decode/execute datapath. It drives a request/acknowledge instruction-memory port with variable latency and buffers fetched words with their PCs in a small prefetch FIFO. Entries are presented to the datapath over a valid/ready handshake. Branch, jump and jr logic redirects fetch through a redirect input, which flushes the buffer and discards any stale in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 4, prefetch FIFO entries; must be a power of 2
PTR_W, 2, log2(DEPTH)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high
redirect  input  1  flush buffer and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0
imem_req  output  1  fetch request; held high until imem_ack
imem_addr  output  32  word-aligned fetch address; stable while imem_req is high
imem_ack  input  1  response valid this cycle; imem_data is sampled in the same cycle
imem_data  input  32  instruction word
inst_valid  output  1  FIFO head is valid
inst_ready  input  1  consumer accepts the head entry
inst_out  output  32  head instruction
inst_pc  output  32  address of the head instruction
fifo_count  output  PTR_W+1  current number of occupied entries

Behaviour:
- Interface: one clock (clock). reset is synchronous and active-high.
- Reset values:
  - state is IDLE; imem_req=0; imem_addr=RESET_PC; fetch_pc=RESET_PC.
  - FIFO pointers and count are 0; storage is cleared, so inst_out=0 and inst_pc=0; inst_valid=0.
- State machine:
  - imem_req is registered and equals (state != IDLE).
  - imem_addr is the registered req_addr.
- IDLE:
  - redirect: fetch_pc <= redirect_pc; stay in IDLE.
  - else if count < DEPTH: req_addr <= fetch_pc; fetch_pc <= fetch_pc+4; go to WAIT.
  - imem_ack in IDLE is ignored.
- WAIT:
  - ack with no redirect: push {imem_data, req_addr}.
    - If the post-push/pop count is < DEPTH, issue the next address the same cycle (req_addr <= fetch_pc, fetch_pc += 4) and stay in WAIT. This gives back-to-back throughput of 1 word/cycle with zero-latency memory.
    - Otherwise go to IDLE.
  - redirect with ack in the same cycle: data is dropped; fetch_pc <= redirect_pc; go to IDLE.
  - redirect without ack: fetch_pc <= redirect_pc; go to DROP.
- DROP:
  - imem_req stays high on the stale address.
  - On ack the data is discarded and the FSM goes to IDLE.
  - A further redirect in DROP overwrites fetch_pc with the newest redirect_pc.
- FIFO:
  - Circular buffer; wr/rd pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - inst_valid = (count != 0). inst_out and inst_pc are read combinationally from the head entry.
  - Pop occurs when inst_valid && inst_ready.
  - Push and pop in the same cycle leave count unchanged.
  - No bypass: a word becomes visible on inst_valid the cycle after its ack.
- Overflow is impossible: a request is issued only when count < DEPTH, and count cannot grow while that request is outstanding.
- Redirect priority: redirect outranks pop and push.
  - Count and pointers are cleared in the redirect cycle.
  - inst_valid is 0 on the next cycle.
  - A pop requested in the redirect cycle is void.
- Address arithmetic: modulo 2^32, so FFFF_FFFC + 4 = 0000_0000.
- Reset mid-operation: outstanding request state is abandoned. An ack arriving in the reset cycle or later while in IDLE is ignored, and imem_req is low the cycle after reset.
- At most one outstanding request at any time.

Test Plan:
1. Reset release, imem_ack tied high, imem_data = addr ^ 32'hA5A5_0000, inst_ready=1 -> imem_req rises 1 cycle after reset drops at addr 0; addrs then run 4, 8, C… one per cycle; inst_pc sequence 0, 4, 8 with matching data; first inst_valid is 1 cycle after the first ack.
2. inst_ready=0, immediate ack -> FIFO fills with PCs 0, 4, 8, C; fifo_count=4; imem_req drops. Raise inst_ready -> entries drain in order, and fetch resumes at 0x10 with no duplicate or skipped PC.
3. Redirect to 0x100 while in WAIT with ack delayed 3 cycles -> imem_addr stays at the old address until ack; that data never appears; the next request is at 0x100; the first delivered inst_pc is 0x100; pre-redirect FIFO entries are never delivered.
4. redirect (redirect_pc=0x203) and imem_ack in the same cycle, with a pop requested -> acked word dropped; inst_valid=0 next cycle; the next imem_addr is 0x200.
5. RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004. Push/pop 10 entries with random inst_ready -> order preserved across pointer wrap.
6. reset asserted while in WAIT with imem_ack high in the same cycle -> no push; fifo_count=0; inst_valid=0; imem_req=0 next cycle; fetch restarts at RESET_PC.
